// File: rtl/lock_ctrl.sv
// lock_ctrl: supervisory controller for the keypad lock FSM.
// Owns the active code register, drives the lock FSM reset, counts alarms,
// enforces a timed lockout and lets the code be reprogrammed while OPEN.
module lock_ctrl #(
    parameter logic [31:0] DEFAULT_SEQ    = 32'h12345678,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1000,
    parameter int unsigned PROG_TIMEOUT   = 500
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        key_valid,
    input  logic [4:0]  keyout,
    input  logic [3:0]  lock_state,
    output logic [31:0] seq,
    output logic        fsm_rst,
    output logic        prog_mode,
    output logic        lockout,
    output logic [3:0]  fail_cnt
);

    // Zero-valued parameters behave as 1.
    localparam int unsigned MAX_FAIL_I  = (MAX_FAIL == 0) ? 1 : MAX_FAIL;
    localparam int unsigned LOCK_CYC_I  = (LOCKOUT_CYCLES == 0) ? 1 : LOCKOUT_CYCLES;
    localparam int unsigned PROG_TO_I   = (PROG_TIMEOUT == 0) ? 1 : PROG_TIMEOUT;

    localparam logic [3:0]  MAX_FAIL_C  = 4'(MAX_FAIL_I);
    localparam logic [15:0] LOCK_RELOAD = 16'(LOCK_CYC_I - 1);
    localparam logic [15:0] PROG_RELOAD = 16'(PROG_TO_I - 1);

    // Lock FSM state codes observed on lock_state.
    localparam logic [3:0] LS_OPEN  = 4'd8;
    localparam logic [3:0] LS_ALARM = 4'd9;
    localparam logic [3:0] LS_INIT  = 4'd10;

    // Keypad encoder codes.
    localparam logic [4:0] KEY_STAR = 5'h10;
    localparam logic [4:0] KEY_HASH = 5'h11;

    localparam logic [3:0] CODE_DIGITS = 4'd8;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_PROG,
        ST_ALARM_WAIT,
        ST_CLR,
        ST_LOCKOUT
    } state_e;

    state_e      state_q,     state_d;
    logic [3:0]  prev_ls_q,   prev_ls_d;
    logic [15:0] timer_q,     timer_d;
    logic [31:0] shadow_q,    shadow_d;
    logic [3:0]  count_q,     count_d;
    logic [31:0] seq_q,       seq_d;
    logic [3:0]  fail_cnt_q,  fail_cnt_d;
    logic        fsm_rst_q,   fsm_rst_d;
    logic        prog_mode_q, prog_mode_d;
    logic        lockout_q,   lockout_d;

    // Key decode: only sampled while key_valid pulses, so held keys never repeat.
    logic is_digit, is_star, is_hash;
    logic alarm_edge, open_edge;
    logic [3:0] fail_inc;

    // Decode keys, detect lock-state edges and form the saturated fail count.
    always_comb begin
        is_digit   = key_valid && (keyout[4] == 1'b0);
        is_star    = key_valid && (keyout == KEY_STAR);
        is_hash    = key_valid && (keyout == KEY_HASH);
        alarm_edge = (lock_state == LS_ALARM) && (prev_ls_q != LS_ALARM);
        open_edge  = (lock_state == LS_OPEN)  && (prev_ls_q != LS_OPEN);
        fail_inc   = (fail_cnt_q >= MAX_FAIL_C) ? MAX_FAIL_C : fail_cnt_q + 4'd1;
    end

    // Next-state logic for the controller FSM and its datapath registers.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; a missing default here would infer a latch.
        state_d    = state_q;
        prev_ls_d  = lock_state;
        timer_d    = timer_q;
        shadow_d   = shadow_q;
        count_d    = count_q;
        seq_d      = seq_q;
        fail_cnt_d = fail_cnt_q;

        unique case (state_q)
            ST_INIT: begin
                state_d = ST_IDLE;
            end

            ST_IDLE: begin
                // An alarm edge wins over any key arriving in the same cycle.
                if (alarm_edge) begin
                    fail_cnt_d = fail_inc;
                    if (fail_inc == MAX_FAIL_C) begin
                        state_d = ST_LOCKOUT;
                        timer_d = LOCK_RELOAD;
                    end else begin
                        state_d = ST_ALARM_WAIT;
                    end
                end else begin
                    if (open_edge) begin
                        fail_cnt_d = 4'd0;
                    end
                    if (is_star && (lock_state == LS_OPEN)) begin
                        state_d  = ST_PROG;
                        shadow_d = 32'd0;
                        count_d  = 4'd0;
                        timer_d  = PROG_RELOAD;
                    end
                end
            end

            ST_PROG: begin
                if (lock_state != LS_OPEN) begin
                    // The lock closed under us: drop the partial code.
                    state_d = ST_IDLE;
                end else if (is_digit) begin
                    if (count_q < CODE_DIGITS) begin
                        shadow_d = {shadow_q[27:0], keyout[3:0]};
                        count_d  = count_q + 4'd1;
                    end
                    timer_d = PROG_RELOAD;
                end else if (is_hash) begin
                    if (count_q == CODE_DIGITS) begin
                        seq_d   = shadow_q;
                        state_d = ST_CLR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (is_star) begin
                    shadow_d = 32'd0;
                    count_d  = 4'd0;
                    timer_d  = PROG_RELOAD;
                end else if (timer_q == 16'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end

            ST_ALARM_WAIT: begin
                if (is_hash) begin
                    state_d = ST_CLR;
                end
            end

            ST_CLR: begin
                state_d = ST_IDLE;
            end

            ST_LOCKOUT: begin
                if (timer_q == 16'd0) begin
                    fail_cnt_d = 4'd0;
                    state_d    = ST_IDLE;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs are decoded from the next state so they line up with it.
    always_comb begin
        fsm_rst_d   = (state_d == ST_INIT) || (state_d == ST_CLR) || (state_d == ST_LOCKOUT);
        prog_mode_d = (state_d == ST_PROG);
        lockout_d   = (state_d == ST_LOCKOUT);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_INIT;
            prev_ls_q   <= LS_INIT;
            timer_q     <= 16'd0;
            // NOTE: the shadow code is a plain register, not a memory, so it is
            // reset with everything else; a partial entry never survives reset.
            shadow_q    <= 32'd0;
            count_q     <= 4'd0;
            seq_q       <= DEFAULT_SEQ;
            fail_cnt_q  <= 4'd0;
            fsm_rst_q   <= 1'b1;
            prog_mode_q <= 1'b0;
            lockout_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            prev_ls_q   <= prev_ls_d;
            timer_q     <= timer_d;
            shadow_q    <= shadow_d;
            count_q     <= count_d;
            seq_q       <= seq_d;
            fail_cnt_q  <= fail_cnt_d;
            fsm_rst_q   <= fsm_rst_d;
            prog_mode_q <= prog_mode_d;
            lockout_q   <= lockout_d;
        end
    end

    assign seq       = seq_q;
    assign fsm_rst   = fsm_rst_q;
    assign prog_mode = prog_mode_q;
    assign lockout   = lockout_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// tb_lock_ctrl: scenario tests for lock_ctrl with randomized keys, gaps and
// codes. Expected codes come from a queue of accepted digits; expected
// durations come from the configured cycle counts.
module tb_lock_ctrl;

    localparam logic [31:0] DEF_SEQ  = 32'h12345678;
    localparam int          MAXF     = 3;
    localparam int          LOCK_CYC = 1000;
    localparam int          PROG_TO  = 500;

    localparam logic [4:0] K_STAR = 5'h10;
    localparam logic [4:0] K_HASH = 5'h11;
    localparam logic [4:0] K_NONE = 5'h1f;

    logic        clk = 1'b0;
    logic        nrst;
    logic        key_valid;
    logic [4:0]  keyout;
    logic [3:0]  lock_state;
    logic [31:0] seq;
    logic        fsm_rst;
    logic        prog_mode;
    logic        lockout;
    logic [3:0]  fail_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] exp_seq;
    int          exp_fail;

    lock_ctrl #(
        .DEFAULT_SEQ   (DEF_SEQ),
        .MAX_FAIL      (MAXF),
        .LOCKOUT_CYCLES(LOCK_CYC),
        .PROG_TIMEOUT  (PROG_TO)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .key_valid (key_valid),
        .keyout    (keyout),
        .lock_state(lock_state),
        .seq       (seq),
        .fsm_rst   (fsm_rst),
        .prog_mode (prog_mode),
        .lockout   (lockout),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    // Hard time limit so a stuck DUT still ends the run.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    // Advance n clock edges, landing 1ns after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle key pulse.
    task automatic press(input logic [4:0] k);
        key_valid = 1'b1;
        keyout    = k;
        step(1);
        key_valid = 1'b0;
        keyout    = K_NONE;
    endtask

    function automatic logic [4:0] rand_digit();
        return 5'($urandom_range(0, 15));
    endfunction

    // Open the lock and enter program mode.
    task automatic enter_prog();
        lock_state = 4'd0;
        step(1);
        lock_state = 4'd8;
        step(1);
        exp_fail = 0;
        press(K_STAR);
    endtask

    // Let the lock FSM follow its reset back to a closed state.
    task automatic lock_follow_reset();
        lock_state = 4'd10;
        step(1);
        lock_state = 4'd0;
        step(1);
    endtask

    task automatic test_reset();
        nrst       = 1'b0;
        key_valid  = 1'b0;
        keyout     = K_NONE;
        lock_state = 4'd10;
        step(2);
        tests_run++;
        if ({fsm_rst, prog_mode, lockout, fail_cnt, seq} !== {1'b1, 1'b0, 1'b0, 4'd0, DEF_SEQ}) begin
            tests_failed++;
            $display("FAIL reset_values: rst=%b prog=%b lock=%b fail=%0d seq=%h expected 1 0 0 0 %h",
                     fsm_rst, prog_mode, lockout, fail_cnt, seq, DEF_SEQ);
        end
        @(negedge clk);
        nrst = 1'b1;
        #1;
        tests_run++;
        if (fsm_rst !== 1'b1) begin
            tests_failed++;
            $display("FAIL init_rst_high: fsm_rst=%b expected 1", fsm_rst);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if ({fsm_rst, prog_mode, lockout, fail_cnt, seq} !== {1'b0, 1'b0, 1'b0, 4'd0, DEF_SEQ}) begin
            tests_failed++;
            $display("FAIL init_release: rst=%b prog=%b lock=%b fail=%0d seq=%h expected 0 0 0 0 %h",
                     fsm_rst, prog_mode, lockout, fail_cnt, seq, DEF_SEQ);
        end
        exp_seq  = DEF_SEQ;
        exp_fail = 0;
    endtask

    task automatic test_alarm();
        int n;
        lock_state = 4'd0;
        step(2);
        lock_state = 4'd9;
        step(1);
        exp_fail++;
        tests_run++;
        if ({fail_cnt, fsm_rst, lockout} !== {4'(exp_fail), 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL alarm_count: fail=%0d rst=%b lock=%b expected %0d 0 0",
                     fail_cnt, fsm_rst, lockout, exp_fail);
        end
        // Non-HASH keys while waiting for the clear are ignored.
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) begin
            press(($urandom_range(0, 1) == 0) ? rand_digit() : K_STAR);
            tests_run++;
            if ({fsm_rst, prog_mode} !== 2'b00) begin
                tests_failed++;
                $display("FAIL alarm_wait_ignore: rst=%b prog=%b expected 0 0", fsm_rst, prog_mode);
            end
        end
        press(K_HASH);
        tests_run++;
        if ({fsm_rst, fail_cnt} !== {1'b1, 4'(exp_fail)}) begin
            tests_failed++;
            $display("FAIL clr_pulse: rst=%b fail=%0d expected 1 %0d", fsm_rst, fail_cnt, exp_fail);
        end
        lock_state = 4'd10;
        step(1);
        tests_run++;
        if ({fsm_rst, fail_cnt} !== {1'b0, 4'(exp_fail)}) begin
            tests_failed++;
            $display("FAIL clr_one_cycle: rst=%b fail=%0d expected 0 %0d", fsm_rst, fail_cnt, exp_fail);
        end
        lock_state = 4'd0;
        step(1);
        // Opening the lock clears the fail count.
        lock_state = 4'd8;
        step(1);
        exp_fail = 0;
        tests_run++;
        if (fail_cnt !== 4'(exp_fail)) begin
            tests_failed++;
            $display("FAIL open_clears: fail=%0d expected 0", fail_cnt);
        end
        lock_state = 4'd0;
        step(1);
    endtask

    task automatic test_lockout();
        int  n;
        bit  rst_ok;
        while (exp_fail < MAXF) begin
            lock_state = 4'd0;
            step(1);
            lock_state = 4'd9;
            // A key landing with the alarm edge must not override it.
            if ($urandom_range(0, 1) == 1) begin
                key_valid = 1'b1;
                keyout    = ($urandom_range(0, 1) == 0) ? K_HASH : K_STAR;
            end
            step(1);
            key_valid = 1'b0;
            keyout    = K_NONE;
            exp_fail++;
            tests_run++;
            if ({fail_cnt, lockout} !== {4'(exp_fail), (exp_fail >= MAXF)}) begin
                tests_failed++;
                $display("FAIL lockout_alarm: fail=%0d lock=%b expected %0d %b",
                         fail_cnt, lockout, exp_fail, (exp_fail >= MAXF));
            end
            if (exp_fail < MAXF) begin
                press(K_HASH);
                lock_follow_reset();
            end
        end
        lock_state = 4'd10;
        n      = 0;
        rst_ok = 1'b1;
        while (lockout === 1'b1 && n < LOCK_CYC + 50) begin
            if (fsm_rst !== 1'b1) rst_ok = 1'b0;
            n++;
            key_valid = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 2))
                0:       keyout = rand_digit();
                1:       keyout = K_STAR;
                default: keyout = K_HASH;
            endcase
            step(1);
        end
        key_valid = 1'b0;
        keyout    = K_NONE;
        exp_fail  = 0;
        tests_run++;
        if (n !== LOCK_CYC) begin
            tests_failed++;
            $display("FAIL lockout_len: lockout high %0d cycles expected %0d", n, LOCK_CYC);
        end
        tests_run++;
        if (rst_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL lockout_rst: fsm_rst dropped during lockout expected held 1");
        end
        tests_run++;
        if ({fail_cnt, lockout, fsm_rst, prog_mode, seq} !== {4'd0, 1'b0, 1'b0, 1'b0, exp_seq}) begin
            tests_failed++;
            $display("FAIL lockout_exit: fail=%0d lock=%b rst=%b prog=%b seq=%h expected 0 0 0 0 %h",
                     fail_cnt, lockout, fsm_rst, prog_mode, seq, exp_seq);
        end
        lock_state = 4'd0;
        step(1);
    endtask

    // Full program session; expected code is built from the accepted-digit queue.
    task automatic program_code(input logic [31:0] code, input int max_gap,
                                input int restart_digits, input int extra_digits,
                                input string tag);
        logic [3:0]  q[$];
        logic [4:0]  d;
        logic [31:0] want;
        enter_prog();
        tests_run++;
        if ({prog_mode, fsm_rst} !== 2'b10) begin
            tests_failed++;
            $display("FAIL %s_entry: prog=%b rst=%b expected 1 0", tag, prog_mode, fsm_rst);
        end
        for (int i = 0; i < restart_digits; i++) begin
            d = rand_digit();
            press(d);
            q.push_back(d[3:0]);
        end
        if (restart_digits > 0) begin
            press(K_STAR);
            q.delete();
        end
        for (int i = 0; i < 8; i++) begin
            step($urandom_range(0, max_gap));
            d = {1'b0, code[31 - 4*i -: 4]};
            press(d);
            if (q.size() < 8) q.push_back(d[3:0]);
        end
        for (int i = 0; i < extra_digits; i++) begin
            d = rand_digit();
            press(d);
            if (q.size() < 8) q.push_back(d[3:0]);
        end
        want = 32'd0;
        foreach (q[i]) want = {want[27:0], q[i]};
        press(K_HASH);
        tests_run++;
        if ({prog_mode, fsm_rst, seq} !== {1'b0, 1'b1, want}) begin
            tests_failed++;
            $display("FAIL %s_commit: prog=%b rst=%b seq=%h expected 0 1 %h", tag, prog_mode, fsm_rst, seq, want);
        end
        exp_seq = want;
        lock_state = 4'd10;
        step(1);
        tests_run++;
        if (fsm_rst !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_clr_len: fsm_rst=%b expected 0", tag, fsm_rst);
        end
        lock_state = 4'd0;
        step(1);
    endtask

    task automatic test_program();
        program_code(32'h87654321, 0, 0, 0, "prog_fixed");
        for (int r = 0; r < 3; r++) begin
            program_code($urandom, 20, $urandom_range(0, 3), $urandom_range(0, 2), "prog_rand");
        end
    endtask

    task automatic test_abort_hash();
        for (int r = 0; r < 2; r++) begin
            int n;
            n = (r == 0) ? 3 : $urandom_range(1, 7);
            enter_prog();
            for (int i = 0; i < n; i++) press(rand_digit());
            press(K_HASH);
            tests_run++;
            if ({prog_mode, fsm_rst, seq} !== {1'b0, 1'b0, exp_seq}) begin
                tests_failed++;
                $display("FAIL abort_hash: digits=%0d prog=%b rst=%b seq=%h expected 0 0 %h",
                         n, prog_mode, fsm_rst, seq, exp_seq);
            end
            lock_state = 4'd0;
            step(1);
        end
    endtask

    task automatic test_timeout();
        enter_prog();
        for (int i = 0; i < 3; i++) press(rand_digit());
        step(PROG_TO - 1);
        tests_run++;
        if (prog_mode !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_early: prog=%b after %0d idle expected 1", prog_mode, PROG_TO - 1);
        end
        // Key arriving as the timer reaches zero is accepted and reloads it.
        press(rand_digit());
        step(PROG_TO - 1);
        tests_run++;
        if (prog_mode !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_reload: prog=%b expected 1", prog_mode);
        end
        step(1);
        tests_run++;
        if ({prog_mode, fsm_rst, seq} !== {1'b0, 1'b0, exp_seq}) begin
            tests_failed++;
            $display("FAIL timeout_abort: prog=%b rst=%b seq=%h expected 0 0 %h", prog_mode, fsm_rst, seq, exp_seq);
        end
        lock_state = 4'd0;
        step(1);
    endtask

    task automatic test_lock_leave();
        enter_prog();
        press(rand_digit());
        press(rand_digit());
        lock_state = 4'd0;
        step(1);
        tests_run++;
        if ({prog_mode, seq} !== {1'b0, exp_seq}) begin
            tests_failed++;
            $display("FAIL lock_leave: prog=%b seq=%h expected 0 %h", prog_mode, seq, exp_seq);
        end
    endtask

    task automatic test_reset_mid_prog();
        program_code(32'h87654321, 3, 0, 0, "prog_pre_rst");
        enter_prog();
        for (int i = 0; i < 5; i++) press(rand_digit());
        #2;
        nrst = 1'b0;
        #1;
        tests_run++;
        if ({fsm_rst, prog_mode, lockout, fail_cnt, seq} !== {1'b1, 1'b0, 1'b0, 4'd0, DEF_SEQ}) begin
            tests_failed++;
            $display("FAIL mid_reset: rst=%b prog=%b lock=%b fail=%0d seq=%h expected 1 0 0 0 %h",
                     fsm_rst, prog_mode, lockout, fail_cnt, seq, DEF_SEQ);
        end
        lock_state = 4'd10;
        step(1);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        exp_seq  = DEF_SEQ;
        exp_fail = 0;
        tests_run++;
        if ({fsm_rst, seq} !== {1'b0, DEF_SEQ}) begin
            tests_failed++;
            $display("FAIL mid_reset_release: rst=%b seq=%h expected 0 %h", fsm_rst, seq, DEF_SEQ);
        end
        program_code($urandom, 5, 0, 0, "prog_post_rst");
    endtask

    task automatic test_back_to_back();
        program_code($urandom, 0, 0, 0, "b2b_first");
        program_code($urandom, 0, 1, 1, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_alarm();
        test_lockout();
        test_program();
        test_abort_hash();
        test_timeout();
        test_lock_leave();
        test_reset_mid_prog();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lock_ctrl.md
Name: lock_ctrl

Overview:
- Supervisory controller for the keypad lock FSM (LS0..LS7, OPEN=8, ALARM=9, INIT=10).
- Owns the 32-bit code register `seq` and drives the lock FSM's reset.
- Counts failed attempts, enforces a timed lockout after repeated alarms, and supports reprogramming the code while the lock is OPEN.
- Sits between the keypad encoder (keyout/strobe) and the lock FSM, on the same clock.

Parameters:
- DEFAULT_SEQ, 32'h12345678, code loaded into seq on reset (8 nibbles, MSB nibble entered first).
- MAX_FAIL, 3, alarms before lockout (1..15).
- LOCKOUT_CYCLES, 1000, clk cycles held in lockout (1..65535).
- PROG_TIMEOUT, 500, idle clk cycles allowed in program mode before abort (1..65535).

Ports:
- clk  in  1  system clock (keypad strobe domain), rising-edge.
- nrst  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle pulse: keyout holds a new key this cycle.
- keyout  in  5  key code. 5'h00-5'h0F = digit nibble; 5'h10 = STAR (program); 5'h11 = HASH (enter/clear); others ignored.
- lock_state  in  4  current state of the lock FSM.
- seq  out  32  active code to the lock FSM.
- fsm_rst  out  1  active-high reset to the lock FSM.
- prog_mode  out  1  high while in PROG.
- lockout  out  1  high while in LOCKOUT.
- fail_cnt  out  4  alarms since last OPEN/lockout expiry; saturates at MAX_FAIL.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on nrst.
- Reset values: seq=DEFAULT_SEQ, fsm_rst=1, prog_mode=0, lockout=0, fail_cnt=0, ctrl state=INIT, timer=0, shadow=0, digit count=0.
- All outputs are registered.
- States: INIT, IDLE, PROG, ALARM_WAIT, CLR, LOCKOUT.
- INIT: one cycle with fsm_rst=1, then IDLE with fsm_rst=0.
- Alarm detect: alarm_edge = (lock_state==9) && (prev lock_state!=9). prev is a register, reset to 10.
- open_edge is defined likewise for lock_state==8.
- IDLE:
  - open_edge -> fail_cnt<=0.
  - alarm_edge -> fail_cnt<=fail_cnt+1, saturating. If the new value == MAX_FAIL -> LOCKOUT with timer<=LOCKOUT_CYCLES-1; else -> ALARM_WAIT.
  - STAR key while lock_state==8 -> PROG with shadow<=0, count<=0, timer<=PROG_TIMEOUT-1.
- PROG (prog_mode=1):
  - Digit key with count<8 -> shadow<={shadow[27:0],keyout[3:0]}, count++, timer reload.
  - Digit key with count==8 -> ignored, but the timer still reloads.
  - HASH with count==8 -> seq<=shadow, then CLR.
  - HASH with count<8 -> abort to IDLE; seq unchanged.
  - STAR -> restart: shadow/count cleared, timer reload.
  - No key -> timer decrements. Timer==0 with no key -> abort to IDLE.
  - lock_state leaving 8 (other than via CLR) -> abort to IDLE.
- ALARM_WAIT: HASH key -> CLR. All other keys ignored.
- CLR: fsm_rst=1 for exactly one cycle, then IDLE. fail_cnt unchanged.
- LOCKOUT (lockout=1, fsm_rst=1 throughout):
  - All keys ignored. Timer decrements each cycle.
  - Timer==0 -> fail_cnt<=0, lockout<=0, fsm_rst<=0, go to IDLE.
  - Total assertion is exactly LOCKOUT_CYCLES cycles.
- Simultaneous events:
  - alarm_edge has priority over any key in the same cycle.
  - In PROG, a key in the same cycle the timer hits 0 is accepted and the timer reloads.
- The controller samples keys only when key_valid=1; held keys do not repeat.
- Reset mid-operation (any state, including PROG with partial shadow or LOCKOUT mid-count): immediate return to reset values. seq reverts to DEFAULT_SEQ.
- Timers are 16-bit. Parameter values of 0 are clamped to 1.
- Implementation sized ~200 RTL lines: FSM, two counters, shadow register, edge detect.

Test Plan:
- Reset release -> fsm_rst=1 for one cycle then 0; seq=32'h12345678; fail_cnt=0; prog_mode=0; lockout=0.
- lock_state driven 0->9 (alarm) -> fail_cnt=1, state ALARM_WAIT. HASH pulse -> fsm_rst high exactly 1 cycle; fail_cnt stays 1.
- Three alarm edges with MAX_FAIL=3 -> lockout=1 and fsm_rst=1 for exactly 1000 cycles. Keys during this window have no effect. Then fail_cnt=0, lockout=0.
- lock_state=8; STAR; digits 8,7,6,5,4,3,2,1; HASH -> seq=32'h87654321, one-cycle fsm_rst, prog_mode falls.
- PROG entry, 3 digits, then HASH -> abort, seq unchanged.
- PROG entry, 3 digits, then 500 idle cycles -> abort, seq unchanged.
- nrst pulsed low mid-PROG after 5 digits (seq previously 32'h87654321) -> outputs immediately at reset values; seq=32'h12345678; subsequent program sequence works normally.
